// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI slave (modes 0-3) with byte-wide tx hold register and rx buffer
//
// Purpose:
//    Byte-oriented SPI slave. The SPI pins are synchronized into the clk domain
//    and all shifting happens on rising clk edges once a synchronized sck edge
//    is seen. The SPI mode comes from the cpol/cpha inputs at run time.
//
// Ports:
//    clk, rst           system clock, asynchronous active-high reset
//    cpol, cpha         SPI mode, static while cs_n is asserted
//    sck, mosi, cs_n    SPI pins from the master (asynchronous to clk)
//    miso, miso_oe      serial data to the master and its drive enable
//    tx_data/tx_valid/tx_ready   next byte to return (one-entry hold register)
//    rx_data/rx_valid/rx_ack     last received byte, unread flag, consume pulse
//    rx_overrun, tx_underrun     sticky error flags
//
// Configuration:
//    SPI_SLAVE_ERR_FLAGS_EN  when defined, builds the sticky error flag logic;
//                            otherwise both flag ports are tied to 0.

module spi_slave (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpol,
   input  logic       cpha,
   input  logic       sck,
   input  logic       mosi,
   input  logic       cs_n,
   output logic       miso,
   output logic       miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       tx_underrun
);

   // Pin synchronizers. sck_s3 and cs_s3 are the extra stages used to detect
   // edges on the synchronized signals.
   logic sck_s1, sck_s2, sck_s3;
   logic mosi_s1, mosi_s2;
   logic cs_s1, cs_s2, cs_s3;

   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic [7:0] hold;
   logic       hold_full;
   logic [2:0] bit_cnt;

   logic       active;
   logic       sck_edge;
   logic       lead_edge;
   logic       trail_edge;
   logic       cs_fall;
   logic       cs_rise;
   logic       sample;
   logic       shift_tx;
   logic       reload;
   logic       complete;
   logic       accept;
   logic [7:0] rx_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_s1  <= 1'b0;
         sck_s2  <= 1'b0;
         sck_s3  <= 1'b0;
         mosi_s1 <= 1'b0;
         mosi_s2 <= 1'b0;
         cs_s1   <= 1'b1;
         cs_s2   <= 1'b1;
         cs_s3   <= 1'b1;
      end else begin
         sck_s1  <= sck;
         sck_s2  <= sck_s1;
         sck_s3  <= sck_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         cs_s1   <= cs_n;
         cs_s2   <= cs_s1;
         cs_s3   <= cs_s2;
      end
   end

   // Edge classification. The leading edge moves sck away from its idle level
   // (cpol), the trailing edge returns it there.
   always_comb begin
      active     = ~cs_s2;
      sck_edge   = sck_s2 ^ sck_s3;
      lead_edge  = active & sck_edge & (sck_s2 != cpol);
      trail_edge = active & sck_edge & (sck_s2 == cpol);
      cs_fall    = cs_s3 & ~cs_s2;
      cs_rise    = ~cs_s3 & cs_s2;
      rx_next    = {rx_shift[6:0], mosi_s2};
      accept     = tx_valid & ~hold_full;

      // A select edge takes priority over any coincident sck edge.
      sample   = 1'b0;
      shift_tx = 1'b0;
      reload   = cs_fall;
      if (!cs_fall) begin
         if (!cpha) begin
            // Mode with cpha=0: capture on leading, drive on trailing. The
            // trailing edge after the 8th capture finds bit_cnt back at 0 and
            // loads the next byte instead of shifting.
            sample = lead_edge;
            if (trail_edge) begin
               if (bit_cnt == 3'd0) begin
                  reload = 1'b1;
               end else begin
                  shift_tx = 1'b1;
               end
            end
         end else begin
            // Mode with cpha=1: drive on leading, capture on trailing. The
            // first leading edge of a byte keeps bit 7 on miso.
            sample   = trail_edge;
            shift_tx = lead_edge & (bit_cnt != 3'd0);
            if (trail_edge && bit_cnt == 3'd7) begin
               reload = 1'b1;
            end
         end
      end
      complete = sample & (bit_cnt == 3'd7);
   end

   // Bit counter: cleared on either select edge so a partial byte is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 3'd0;
      end else if (cs_fall || cs_rise) begin
         bit_cnt <= 3'd0;
      end else if (sample) begin
         bit_cnt <= bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_shift <= 8'h00;
      end else if (sample) begin
         rx_shift <= rx_next;
      end
   end

   // Transmit shifter. An empty hold at reload time returns all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_shift <= 8'hFF;
      end else if (reload) begin
         tx_shift <= hold_full ? hold : 8'hFF;
      end else if (shift_tx) begin
         tx_shift <= {tx_shift[6:0], 1'b1};
      end
   end

   // Hold register. accept needs an empty hold and a reload only clears a
   // full hold, so the two never act on hold_full in the same cycle; an
   // accept alongside a reload of an empty hold stays in the hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold      <= 8'h00;
         hold_full <= 1'b0;
      end else begin
         if (accept) begin
            hold <= tx_data;
         end
         if (reload && hold_full) begin
            hold_full <= 1'b0;
         end else if (accept) begin
            hold_full <= 1'b1;
         end
      end
   end

   // Receive buffer. A completing byte beats a same-cycle rx_ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else if (complete) begin
         rx_data  <= rx_next;
         rx_valid <= 1'b1;
      end else if (rx_ack) begin
         rx_valid <= 1'b0;
      end
   end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
   // Sticky flags; a set event wins over a same-cycle clear.
   logic rx_overrun_r;
   logic tx_underrun_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_overrun_r  <= 1'b0;
         tx_underrun_r <= 1'b0;
      end else begin
         if (complete && rx_valid && !rx_ack) begin
            rx_overrun_r <= 1'b1;
         end else if (rx_ack) begin
            rx_overrun_r <= 1'b0;
         end
         if (reload && !hold_full) begin
            tx_underrun_r <= 1'b1;
         end else if (accept) begin
            tx_underrun_r <= 1'b0;
         end
      end
   end

   assign rx_overrun  = rx_overrun_r;
   assign tx_underrun = tx_underrun_r;
`else
   assign rx_overrun  = 1'b0;
   assign tx_underrun = 1'b0;
`endif

   assign miso     = tx_shift[7];
   assign miso_oe  = ~cs_s2;
   assign tx_ready = ~hold_full;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have no parameters; the SPI mode is selected at run time by the cpol and cpha inputs.
REQ-002 clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cpol, cpha  input  1 each  SPI mode; held static while cs_n is asserted.
REQ-005 sck, mosi, cs_n  input  1 each  SPI pins from the master; asynchronous to clk.
REQ-006 miso  output  1  serial data to the master; equal to tx_shift[7].
REQ-007 miso_oe  output  1  miso drive enable; high only while the synchronized cs_n is low.
REQ-008 tx_data  input  8  next byte to return to the master; tx_valid  input  1  offer; tx_ready  output  1  hold register empty.
REQ-009 rx_data  output  8  last complete received byte; rx_valid  output  1  level, unread byte present; rx_ack  input  1  consume pulse.
REQ-010 rx_overrun, tx_underrun  output  1 each  sticky error flags (see Configuration).

Function
REQ-011 SHALL pass sck, mosi and cs_n through 2-flop synchronizers, plus one extra sck stage for edge detection; pin-to-action latency is 3 clk.
REQ-012 SHALL operate correctly when each sck half-period is at least 4 clk cycles.
REQ-013 SHALL treat the leading edge as the sck transition away from cpol, and the trailing edge as the transition back to cpol.
REQ-014 SHALL act on sck edges only while the synchronized cs_n is low.
REQ-015 On a synchronized cs_n falling edge, SHALL set bit_cnt (3 bits) to 0 and perform a reload (REQ-019).
REQ-016 cpha=0 behaviour:
- Leading edge: rx_shift <= {rx_shift[6:0], mosi_s}, bit_cnt increments.
- Trailing edge: reload if bit_cnt==0, otherwise shift tx_shift left by one.
REQ-017 cpha=1 behaviour:
- Leading edge: shift tx_shift left if bit_cnt!=0; no shift when bit_cnt==0.
- Trailing edge: sample mosi and increment bit_cnt; reload when bit_cnt wraps 7->0.
REQ-018 When bit_cnt wraps 7->0, SHALL in the same cycle load rx_data with the completed byte and set rx_valid.
REQ-019 Reload SHALL load tx_shift from the hold register and clear hold_full when the hold is full; if the hold is empty, tx_shift SHALL be loaded with 8'hFF.
REQ-020 tx_ready = ~hold_full; a transfer with tx_valid & tx_ready high SHALL write the hold register and set hold_full.
REQ-021 When an accept and a reload coincide on an empty hold, the reload SHALL use 8'hFF and the accepted byte SHALL remain in the hold.
REQ-022 rx_ack SHALL clear rx_valid; a byte completing in the same cycle as rx_ack SHALL win, leaving rx_valid=1 with the new data.
REQ-023 A byte completing while rx_valid=1 SHALL overwrite rx_data.
REQ-024 A synchronized cs_n rising edge mid-byte SHALL discard the partial byte: bit_cnt returns to 0, no rx_valid, and the hold register keeps its contents.
REQ-025 Edges on sck while cs_n is high SHALL change no state.

Reset
REQ-026 On rst, SHALL set: tx_shift=8'hFF (miso=1), miso_oe=0, rx_data=0, rx_valid=0, hold_full=0 (tx_ready=1), bit_cnt=0, both flags=0.
REQ-027 On rst, SHALL set the cs_n synchronizer stages to 1 and the sck and mosi synchronizer stages to 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer; after reset release, no activity occurs until the next cs_n falling edge.

Configuration
REQ-029 With SPI_SLAVE_ERR_FLAGS_EN defined:
- rx_overrun SHALL set when a byte completes while rx_valid=1 and rx_ack=0.
- tx_underrun SHALL set when a reload finds the hold empty.
- Both flags SHALL clear on rx_ack (rx_overrun) and on an accepted tx_valid (tx_underrun); a set event in the same cycle as a clear wins.
REQ-030 Without SPI_SLAVE_ERR_FLAGS_EN, both flag ports SHALL be tied to 0 and no flag logic SHALL be generated.

Verification
REQ-031 Mode 0, hold=8'hA5, master sends 8'h3C -> miso carries A5 MSB first; rx_data=8'h3C, rx_valid=1 after the 8th leading edge; tx_ready=1.
REQ-032 Mode 3, two back-to-back bytes with holds 8'h81 then 8'h7E -> miso carries 81 then 7E; two rx_valid events with correct data.
REQ-033 Empty hold, mode 1, 1 byte -> miso=8'hFF; tx_underrun=1 (flags enabled), 0 (flags disabled).
REQ-034 cs_n deasserted after 5 bits, then a full byte 8'hC3 -> only 8'hC3 is reported; miso_oe falls within 3 clk of cs_n high.
REQ-035 Two bytes with no rx_ack -> rx_data equals the 2nd byte and rx_overrun=1; rx_ack clears rx_valid and rx_overrun.
REQ-036 rst pulsed mid-byte -> all outputs at reset values; the next full transfer completes correctly.
